// File: rtl/heater_thermostat.sv
// Hysteresis heater thermostat fed by a raw DS18B20 temperature word.
// Periodic sampling, min hold between relay changes, over-temp and sensor-fault latching.
module heater_thermostat #(
    parameter int SAMPLE_PERIOD = 27_000_000,
    parameter int HYST          = 2,
    parameter int MIN_HOLD      = 5,
    parameter int MAX_TEMP      = 90,
    parameter int FAULT_LIMIT   = 3
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] TEMPERATURE,
    input  logic [7:0]  SETPOINT,
    input  logic        ENABLE,
    input  logic        FAULT_CLR,
    output logic        HEATER_ON,
    output logic        FAULT,
    output logic [7:0]  TEMP_C,
    output logic [1:0]  STATE
);
    typedef enum logic [1:0] {
        S_DISABLED = 2'd0,
        S_HEAT     = 2'd1,
        S_REST     = 2'd2,
        S_FAULT    = 2'd3
    } state_t;

    localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int HW = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
    localparam int IW = (FAULT_LIMIT > 0) ? $clog2(FAULT_LIMIT + 1) : 1;
    localparam logic [7:0]        SP_MAX = 8'(MAX_TEMP - 1);
    localparam logic signed [9:0] HYST_S = 10'(HYST);
    localparam logic signed [9:0] MAX_S  = 10'(MAX_TEMP);

    logic [TW-1:0] timer;
    logic          tick, raw_valid;
    logic          vtick_q, itick_q, enable_q;
    logic [IW-1:0] inv_cnt;
    logic [HW-1:0] hold;
    logic          hold_ok, inv_limit;
    logic [7:0]    sp;
    logic signed [9:0] temp_s, sp_s, low_s;
    state_t state, next;

    assign tick      = (timer == TW'(SAMPLE_PERIOD - 1));
    assign raw_valid = (TEMPERATURE != 16'h0000) && (TEMPERATURE != 16'h0550);

    // Sample stage: capture on the tick; the FSM sees the result one cycle later.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            timer    <= '0;
            vtick_q  <= 1'b0;
            itick_q  <= 1'b0;
            enable_q <= 1'b0;
            TEMP_C   <= 8'd0;
            inv_cnt  <= '0;
        end else begin
            timer    <= tick ? '0 : timer + TW'(1);
            vtick_q  <= tick && raw_valid;
            itick_q  <= tick && !raw_valid;
            enable_q <= ENABLE;
            if (tick && raw_valid)
                TEMP_C <= TEMPERATURE[11:4];
            if (state == S_FAULT && FAULT_CLR)
                inv_cnt <= '0;
            else if (tick) begin
                if (raw_valid)
                    inv_cnt <= '0;
                else if (inv_cnt != IW'(FAULT_LIMIT))
                    inv_cnt <= inv_cnt + IW'(1);
            end
        end
    end

    // 10-bit signed math keeps low threshold from wrapping at small setpoints.
    always_comb begin
        sp     = (SETPOINT > SP_MAX) ? SP_MAX : SETPOINT;
        temp_s = {{2{TEMP_C[7]}}, TEMP_C};
        sp_s   = {2'b00, sp};
        low_s  = sp_s - HYST_S;
    end

    assign hold_ok   = (hold >= HW'(MIN_HOLD));
    assign inv_limit = itick_q && (inv_cnt == IW'(FAULT_LIMIT));

    always_comb begin
        next = state;
        case (state)
            S_DISABLED: begin
                if (vtick_q && temp_s >= MAX_S)
                    next = S_FAULT;
                else if (vtick_q && enable_q)
                    next = (temp_s < low_s) ? S_HEAT : S_REST;
            end
            S_HEAT: begin
                if ((vtick_q && temp_s >= MAX_S) || inv_limit)
                    next = S_FAULT;
                else if (!enable_q)
                    next = S_DISABLED;
                else if (vtick_q && temp_s >= sp_s && hold_ok)
                    next = S_REST;
            end
            S_REST: begin
                if ((vtick_q && temp_s >= MAX_S) || inv_limit)
                    next = S_FAULT;
                else if (!enable_q)
                    next = S_DISABLED;
                else if (vtick_q && temp_s < low_s && hold_ok)
                    next = S_HEAT;
            end
            S_FAULT: begin
                if (FAULT_CLR)
                    next = S_DISABLED;
            end
            default: next = S_DISABLED;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_DISABLED;
            HEATER_ON <= 1'b0;
            hold      <= HW'(MIN_HOLD);
        end else begin
            state     <= next;
            HEATER_ON <= (next == S_HEAT);
            if ((next == S_HEAT) != HEATER_ON)
                hold <= '0;
            else if (vtick_q && !hold_ok)
                hold <= hold + HW'(1);
        end
    end

    assign FAULT = (state == S_FAULT);
    assign STATE = state;
endmodule

// File: tb/tb_heater_thermostat.sv
// Self-checking bench: directed scenarios pinned by literal values, then random
// stimulus compared every cycle against a behavioural thermostat model.
module tb_heater_thermostat;
    localparam int SAMPLE_PERIOD = 10;
    localparam int HYST          = 2;
    localparam int MIN_HOLD      = 2;
    localparam int MAX_TEMP      = 90;
    localparam int FAULT_LIMIT   = 3;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] TEMPERATURE = 16'h0190;
    logic [7:0]  SETPOINT = 8'd40;
    logic        ENABLE = 1'b0;
    logic        FAULT_CLR = 1'b0;
    logic        HEATER_ON, FAULT;
    logic [7:0]  TEMP_C;
    logic [1:0]  STATE;

    int checks = 0;
    int errors = 0;

    heater_thermostat #(
        .SAMPLE_PERIOD(SAMPLE_PERIOD), .HYST(HYST), .MIN_HOLD(MIN_HOLD),
        .MAX_TEMP(MAX_TEMP), .FAULT_LIMIT(FAULT_LIMIT)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .TEMPERATURE(TEMPERATURE), .SETPOINT(SETPOINT),
        .ENABLE(ENABLE), .FAULT_CLR(FAULT_CLR), .HEATER_ON(HEATER_ON),
        .FAULT(FAULT), .TEMP_C(TEMP_C), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0=disabled 1=heat 2=rest 3=fault; temperatures as plain ints.
    int m_cnt = 0, m_temp = 0, m_inv = 0, m_mode = 0, m_hold = MIN_HOLD, m_heat = 0;
    bit m_pend_v = 0, m_pend_i = 0, m_en_q = 0;

    always @(posedge CLK or negedge RST_N) begin : model
        int sp, low, nm, nh, nhold, ninv, ntemp;
        bit tk, ok, fe;
        logic signed [7:0] t8;
        if (!RST_N) begin
            m_cnt <= 0; m_temp <= 0; m_inv <= 0; m_mode <= 0;
            m_hold <= MIN_HOLD; m_heat <= 0; m_pend_v <= 0; m_pend_i <= 0; m_en_q <= 0;
        end else begin
            sp  = (int'(SETPOINT) > MAX_TEMP - 1) ? MAX_TEMP - 1 : int'(SETPOINT);
            low = sp - HYST;
            fe  = (m_mode != 3 && m_pend_v && m_temp >= MAX_TEMP) ||
                  ((m_mode == 1 || m_mode == 2) && m_pend_i && m_inv == FAULT_LIMIT);
            nm = m_mode;
            if (fe) nm = 3;
            else if (m_mode == 3) begin
                if (FAULT_CLR) nm = 0;
            end else if (!m_en_q) nm = 0;
            else if (m_pend_v) begin
                if (m_mode == 0) nm = (m_temp < low) ? 1 : 2;
                else if (m_mode == 1 && m_temp >= sp && m_hold >= MIN_HOLD) nm = 2;
                else if (m_mode == 2 && m_temp < low && m_hold >= MIN_HOLD) nm = 1;
            end
            nh = (nm == 1) ? 1 : 0;
            nhold = m_hold;
            if (nh != m_heat) nhold = 0;
            else if (m_pend_v && m_hold < MIN_HOLD) nhold = m_hold + 1;

            tk = (m_cnt == SAMPLE_PERIOD - 1);
            ok = (TEMPERATURE != 16'h0000) && (TEMPERATURE != 16'h0550);
            ninv = m_inv;
            if (m_mode == 3 && FAULT_CLR) ninv = 0;
            else if (tk) ninv = ok ? 0 : ((m_inv + 1 > FAULT_LIMIT) ? FAULT_LIMIT : m_inv + 1);
            ntemp = m_temp;
            if (tk && ok) begin
                t8 = TEMPERATURE[11:4];
                ntemp = t8;
            end
            m_cnt <= (m_cnt + 1) % SAMPLE_PERIOD;
            m_inv <= ninv; m_temp <= ntemp; m_mode <= nm; m_heat <= nh; m_hold <= nhold;
            m_pend_v <= tk && ok; m_pend_i <= tk && !ok; m_en_q <= ENABLE;
        end
    end

    always @(negedge CLK) begin
        if (RST_N) begin
            chk("model_heater", int'(HEATER_ON), m_heat);
            chk("model_fault", int'(FAULT), (m_mode == 3) ? 1 : 0);
            chk("model_temp_c", int'(TEMP_C), m_temp & 8'hFF);
            chk("model_state", int'(STATE), m_mode);
        end
    end

    // Returns at the negedge right after a tick edge (TEMP_C updated, FSM edge next).
    task automatic next_tick();
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(m_pend_v || m_pend_i) && n < 40);
        if (n >= 40) chk("tick_timeout", n, 0);
    endtask

    task automatic pulse_clr();
        FAULT_CLR = 1'b1;
        @(negedge CLK);
        FAULT_CLR = 1'b0;
    endtask

    initial begin
        int deg;
        repeat (3) @(negedge CLK);
        chk("rst_heater", int'(HEATER_ON), 0);
        chk("rst_fault", int'(FAULT), 0);
        chk("rst_temp", int'(TEMP_C), 0);
        chk("rst_state", int'(STATE), 0);
        ENABLE = 1'b1;
        RST_N = 1'b1;

        // Turn-on from 25 C with setpoint 40.
        next_tick();
        chk("first_temp", int'(TEMP_C), 25);
        chk("first_state_pre", int'(STATE), 0);
        @(negedge CLK);
        chk("first_state", int'(STATE), 1);
        chk("first_heater", int'(HEATER_ON), 1);

        // Reach setpoint: min hold delays the switch to rest.
        TEMPERATURE = 16'h0280;
        next_tick(); @(negedge CLK); chk("hold_heat1", int'(STATE), 1);
        next_tick(); @(negedge CLK); chk("hold_heat2", int'(STATE), 1);
        next_tick(); @(negedge CLK); chk("to_rest", int'(STATE), 2);
        chk("rest_heater", int'(HEATER_ON), 0);
        TEMPERATURE = 16'h0260;
        next_tick(); next_tick(); @(negedge CLK); chk("at_low_rest", int'(STATE), 2);
        TEMPERATURE = 16'h025F;
        next_tick(); @(negedge CLK); chk("below_low_heat", int'(STATE), 1);

        // Back to rest, then over-temperature with a clear on the trip cycle.
        TEMPERATURE = 16'h0280;
        next_tick(); next_tick(); next_tick(); @(negedge CLK);
        chk("rest_again", int'(STATE), 2);
        TEMPERATURE = 16'h05A0;
        next_tick();
        pulse_clr();
        chk("trip_state", int'(STATE), 3);
        chk("trip_fault", int'(FAULT), 1);
        chk("trip_heater", int'(HEATER_ON), 0);
        TEMPERATURE = 16'h0190;
        next_tick(); @(negedge CLK);
        pulse_clr();
        chk("clr_state", int'(STATE), 0);
        chk("clr_fault", int'(FAULT), 0);

        // Invalid samples: three in a row fault, two then a valid one do not.
        next_tick(); @(negedge CLK); chk("reheat", int'(STATE), 1);
        TEMPERATURE = 16'h0550;
        next_tick(); next_tick(); @(negedge CLK);
        chk("inv2_state", int'(STATE), 1);
        chk("inv2_temp", int'(TEMP_C), 25);
        next_tick(); @(negedge CLK);
        chk("inv3_state", int'(STATE), 3);
        TEMPERATURE = 16'h0190;
        next_tick(); @(negedge CLK);
        pulse_clr();
        next_tick(); @(negedge CLK); chk("post_clr_heat", int'(STATE), 1);
        TEMPERATURE = 16'h0000;
        next_tick(); next_tick();
        TEMPERATURE = 16'h0190;
        next_tick(); @(negedge CLK); chk("inv2_valid", int'(STATE), 1);
        next_tick(); @(negedge CLK); chk("inv2_valid2", int'(STATE), 1);

        // Small setpoint: low threshold goes negative without wrapping.
        SETPOINT = 8'd1;
        TEMPERATURE = 16'hFFF0;
        ENABLE = 1'b0;
        repeat (3) @(negedge CLK);
        ENABLE = 1'b1;
        next_tick(); chk("neg1_temp", int'(TEMP_C), 8'hFF);
        @(negedge CLK); chk("neg1_rest", int'(STATE), 2);
        TEMPERATURE = 16'hFFE0;
        next_tick(); chk("neg2_temp", int'(TEMP_C), 8'hFE);
        next_tick(); next_tick(); @(negedge CLK);
        chk("neg2_heat", int'(STATE), 1);

        // Enable drop mid-period, then asynchronous reset mid-heat.
        ENABLE = 1'b0;
        @(negedge CLK); @(negedge CLK);
        chk("en_drop_heater", int'(HEATER_ON), 0);
        chk("en_drop_state", int'(STATE), 0);
        ENABLE = 1'b1;
        next_tick(); @(negedge CLK); chk("reen_heat", int'(STATE), 1);
        @(negedge CLK); #2 RST_N = 1'b0;
        #1;
        chk("async_heater", int'(HEATER_ON), 0);
        chk("async_state", int'(STATE), 0);
        chk("async_temp", int'(TEMP_C), 0);
        chk("async_fault", int'(FAULT), 0);
        @(negedge CLK); RST_N = 1'b1;

        // Random phase checked by the model.
        SETPOINT = 8'd40;
        for (int c = 0; c < 4000; c++) begin
            @(negedge CLK);
            RST_N = ($urandom_range(0, 1499) != 0);
            FAULT_CLR = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 149) == 0) ENABLE = ~ENABLE;
            if ($urandom_range(0, 199) == 0) SETPOINT = 8'($urandom_range(0, 100));
            if ($urandom_range(0, 14) == 0) begin
                case ($urandom_range(0, 9))
                    0: TEMPERATURE = 16'h0000;
                    1: TEMPERATURE = 16'h0550;
                    2: TEMPERATURE = 16'(int'($urandom_range(86, 95)) * 16 + int'($urandom_range(0, 15)));
                    default: begin
                        deg = int'(SETPOINT) + int'($urandom_range(0, 8)) - 5;
                        TEMPERATURE = 16'(deg * 16 + int'($urandom_range(0, 15)));
                    end
                endcase
            end
        end
        RST_N = 1'b1;
        FAULT_CLR = 1'b0;
        repeat (5) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
